// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 4-register datapath.
// Fetch and decode both import this package so they agree on the instruction format.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int REG_ADDR_W = 2;
  localparam int IMM_W      = 8;

  // Opcode occupies the top nibble of every instruction word
  typedef enum logic [OPCODE_W-1:0] {
    OP_LW  = 4'b0000,
    OP_SW  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOT = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_BEQ = 4'b1010,
    OP_BNE = 4'b1011,
    OP_LI  = 4'b1100,
    OP_CLR = 4'b1101
  } opcode_t;

  function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] word);
    return opcode_t'(word[INSTR_W-1 -: OPCODE_W]);
  endfunction

  function automatic logic is_branch(input logic [INSTR_W-1:0] word);
    return (get_opcode(word) == OP_BEQ) || (get_opcode(word) == OP_BNE);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer between the memory response and the decoder.
// A push into an empty buffer is not visible on dout until the following cycle.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      storage[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory,
// buffers returned words and hands them to the decoder over valid/ready.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int CW     = $clog2(DEPTH+1);
  localparam int FIFO_W = INSTR_W + PC_W;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   inflight_pc;
  logic              started;
  logic              inflight;
  logic              pop;
  logic              push;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic [CW:0]       occupancy;
  logic [FIFO_W-1:0] fifo_dout;

  // A redirect takes priority over a decoder accept and squashes the returning word
  assign instr_valid = ~empty;
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign push        = inflight & ~redirect;

  // Slots already promised: buffered words plus the read in flight, minus this cycle's pop
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_en   = started & ~redirect & (occupancy < DEPTH_L);
  assign imem_addr = pc;

  assign {instr, instr_pc} = fifo_dout;

  // Holds fetch off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (imem_en) begin
      pc <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_rdata, inflight_pc}),
    .dout  (fifo_dout),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  a_no_issue_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_en && full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// ready/redirect traffic, all compared against a queue-based reference model.
module tb_instr_fetch;

  localparam int PC_W  = 8;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata = '0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic [15:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready = 1'b0;

  logic [15:0] mem [256];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model: every issued request waits in a queue until its word is due
  typedef struct {
    logic [PC_W-1:0] pc;
    int              due;
  } req_t;

  req_t            pending[$];
  logic [PC_W-1:0] fetch_pc;
  int              cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  instr_fetch #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    pending.delete();
    fetch_pc = 8'h00;
    cyc      = 1;
  endtask

  task automatic modelCycle();
    bit exp_valid;
    bit exp_pop;
    bit exp_en;
    exp_valid = (pending.size() > 0) && (pending[0].due <= cyc);
    checkOutput("model_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("model_instr_pc", 32'(instr_pc), 32'(pending[0].pc));
      checkOutput("model_instr", 32'(instr), 32'(mem[pending[0].pc]));
    end
    exp_pop = exp_valid && instr_ready && !redirect;
    exp_en  = !redirect && ((pending.size() - (exp_pop ? 1 : 0)) < DEPTH);
    checkOutput("model_imem_en", 32'(imem_en), 32'(exp_en));
    if (exp_en) checkOutput("model_imem_addr", 32'(imem_addr), 32'(fetch_pc));
    if (redirect) begin
      pending.delete();
      fetch_pc = redirect_pc;
    end else begin
      if (exp_pop) void'(pending.pop_front());
      if (exp_en) begin
        pending.push_back('{pc: fetch_pc, due: cyc + 2});
        fetch_pc = fetch_pc + 8'h01;
      end
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [PC_W-1:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    modelCycle();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_imem_en"}, 32'(imem_en), 32'd0);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_instr"}, 32'(instr), 32'd0);
    checkOutput({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h2000 + 16'(a);

    // Reset state
    #12;
    checkResetOutputs("reset");
    releaseReset();

    // Startup: first request in cycle 1, first word valid in cycle 3
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("start_en", 32'(imem_en), 32'd1);
    checkOutput("start_addr", 32'(imem_addr), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("start_c2_valid", 32'(instr_valid), 32'd0);

    // Backpressure for 5 cycles right after the first word appears
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_instr", 32'(instr), 32'h2000);
      checkOutput("stall_imem_en", 32'(imem_en), 32'd0);
    end

    // Release: in-order delivery with no bubbles
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("stream_valid", 32'(instr_valid), 32'd1);
      checkOutput("stream_pc", 32'(instr_pc), 32'(k));
    end

    // Redirect to 0x40 with a read in flight and the decoder stalled
    applyStimulus(1'b0, 1'b1, 8'h40);
    checkOutput("redir40_en", 32'(imem_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("redir40_t1_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir40_t1_en", 32'(imem_en), 32'd1);
    checkOutput("redir40_t1_addr", 32'(imem_addr), 32'h40);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("redir40_t2_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("redir40_t3_valid", 32'(instr_valid), 32'd1);
    checkOutput("redir40_t3_pc", 32'(instr_pc), 32'h40);
    checkOutput("redir40_t3_instr", 32'(instr), 32'h2040);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 8'h00);

    // Redirect and ready together: the shown word is not consumed
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("redir80_valid_at_t", 32'(instr_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("redir80_pc", 32'(instr_pc), 32'h80);

    // PC wraps from 0xFF to 0x00
    applyStimulus(1'b1, 1'b1, 8'hFE);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [PC_W-1:0] wrap_pc;
      wrap_pc = 8'hFE + 8'(k);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("wrap_valid", 32'(instr_valid), 32'd1);
      checkOutput("wrap_pc", 32'(instr_pc), 32'(wrap_pc));
    end

    // Back-to-back redirects: the second one wins
    applyStimulus(1'b1, 1'b1, 8'h10);
    applyStimulus(1'b1, 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("b2b_pc", 32'(instr_pc), 32'h20);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 8'h00);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    releaseReset();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("restart_addr", 32'(imem_addr), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("restart_pc", 32'(instr_pc), 32'h00);
    checkOutput("restart_instr", 32'(instr), 32'h2000);

    // Random traffic against random memory contents
    @(negedge clk);
    rst_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    releaseReset();
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
